// File: rtl/rv_pulse_issue.sv
// rtl/rv_pulse_issue.sv - ready-valid to pulse-valid issue buffer with minimum pulse spacing II.
// Optional stall counter output enabled by defining RV_PULSE_ISSUE_STALL_CNT_EN.
module rv_pulse_issue #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int II    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  output logic                         ready_i,
  input  logic [W-1:0]                 in,
  output logic                         valid_o,
  output logic [W-1:0]                 out,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         idle
`ifdef RV_PULSE_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(II + 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(II - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  out_q, out_d;
  logic          accept;
  logic          issue;

  // Ready looks only at registered occupancy: a same-cycle issue never opens a slot.
  assign ready_i = !reset && (count_q < FULL);
  assign accept  = valid_i && ready_i;
  assign issue   = (count_q != '0) && (gap_q == '0);

  always_comb begin
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    out_d   = out_q;

    if (accept) begin
      mem_d[tail_q] = in;
      tail_d        = tail_q + 1'b1;
    end

    if (issue) begin
      out_d   = mem_q[head_q];
      valid_d = 1'b1;
      head_d  = head_q + 1'b1;
      gap_d   = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    case ({accept, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_o = valid_q;
  assign out     = out_q;
  assign count_o = count_q;
  assign idle    = (count_q == '0) && (gap_q == '0);

`ifdef RV_PULSE_ISSUE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_i && !ready_i && !reset && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rv_pulse_issue.sv
// tb/tb_rv_pulse_issue.sv - checks rv_pulse_issue instances with II=1..5 against a queue model.
module tb_rv_pulse_issue;

  logic        clk;
  logic        reset;
  logic [4:0]  vld;
  logic [31:0] din;
  logic        rdy    [5];
  logic        vo     [5];
  logic [31:0] dout   [5];
  logic [2:0]  cnt    [5];
  logic        idle_w [5];
`ifdef RV_PULSE_ISSUE_STALL_CNT_EN
  logic [31:0] stall  [5];
`endif

  genvar g;
  generate
    for (g = 0; g < 5; g++) begin : g_dut
      rv_pulse_issue #(.W(32), .DEPTH(4), .II(g + 1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (vld[g]),
        .ready_i  (rdy[g]),
        .in       (din),
        .valid_o  (vo[g]),
        .out      (dout[g]),
        .count_o  (cnt[g]),
        .idle     (idle_w[g])
`ifdef RV_PULSE_ISSUE_STALL_CNT_EN
        ,
        .stall_cnt(stall[g])
`endif
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int pass  = 0;
  int nfail = 0;

  // Reference model: queue of buffered words plus the earliest cycle the next pulse may issue.
  logic [31:0] mq[$];
  logic [31:0] m_out;
  int          cyc, next_ok, last_pulse, cur_ii, m_stall;
  int          pulses, max_cnt, first_pulse, last_seen;
  bit          saw_rdy0, saw_full_issue;
  logic [31:0] issued[$];
  logic [31:0] sent[$];

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] d;
    bit          rdy;
    bit          vo;
    logic [31:0] out;
    int          cnt;
    bit          idle;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      pass++;
    end else begin
      if (nfail < 30) $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      nfail++;
    end
  endtask

  function automatic vec_t mkv(bit rst, bit v, logic [31:0] d, bit r, bit o, logic [31:0] q,
                               int c, bit i);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = r; t.vo = o; t.out = q; t.cnt = c; t.idle = i;
    return t;
  endfunction

  task automatic clear_stats();
    pulses = 0; max_cnt = 0; saw_rdy0 = 0; saw_full_issue = 0;
    first_pulse = -1; last_seen = -1;
    issued.delete(); sent.delete();
  endtask

  task automatic do_reset(input int s);
    reset = 1'b1;
    vld   = '0;
    #1;
    chk("rst_ready", rdy[s], 0);
    chk("rst_valid_o", vo[s], 0);
    chk("rst_count", cnt[s], 0);
    chk("rst_out", dout[s], 0);
    chk("rst_idle", idle_w[s], 1);
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); m_out = '0; cyc = 0; next_ok = 0; last_pulse = -100; m_stall = 0;
  endtask

  task automatic cycle(input int s, input bit v, input logic [31:0] d, output bit acc);
    bit er, iss;
    vld = '0; vld[s] = v; din = d;
    #1;
    er = (mq.size() < 4);
    chk("ready_i", rdy[s], er);
    if (!er) saw_rdy0 = 1;
    acc = v && er;
    if (v && !er) m_stall++;
    iss = (mq.size() > 0) && (cyc >= next_ok);
    if (iss) begin
      m_out   = mq.pop_front();
      next_ok = cyc + cur_ii;
    end
    if (acc) begin
      mq.push_back(d);
      sent.push_back(d);
    end
    @(posedge clk); #1;
    cyc++;
    chk("valid_o", vo[s], iss);
    chk("out", dout[s], m_out);
    chk("count_o", cnt[s], mq.size());
    chk("idle", idle_w[s], (mq.size() == 0) && (cyc >= next_ok));
    if (vo[s]) begin
      pulses++;
      issued.push_back(dout[s]);
      chk("spacing", (cyc - last_pulse) >= cur_ii, 1);
      last_pulse = cyc;
      if (first_pulse < 0) first_pulse = cyc;
      last_seen = cyc;
      if (!er) saw_full_issue = 1;
    end
    if (int'(cnt[s]) > max_cnt) max_cnt = int'(cnt[s]);
  endtask

  task automatic push_hold(input int s, input logic [31:0] d);
    bit acc;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) cycle(s, 1'b1, d, acc);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain(input int s, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(s, 1'b0, '0, acc);
  endtask

  task automatic check_order(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_len"}, issued.size(), sent.size());
    for (int i = 0; i < issued.size() && i < sent.size(); i++)
      if (issued[i] !== sent[i]) bad++;
    chk({nm, "_order"}, bad, 0);
  endtask

  initial begin
    bit          acc, found, pending;
    int          ii, s, nsent;
    logic [31:0] word;

    reset = 1'b1; vld = '0; din = '0;
    cyc = 0; next_ok = 0; last_pulse = -100; cur_ii = 1; m_stall = 0; m_out = '0;
    clear_stats();
    @(posedge clk); #1;

    // Single-word latency and hold on the II=1 instance.
    tv[0] = mkv(1, 0, 32'h0,  0, 0, 32'h0,  0, 1);
    tv[1] = mkv(0, 0, 32'h0,  1, 0, 32'h0,  0, 1);
    tv[2] = mkv(0, 1, 32'hA5, 1, 0, 32'h0,  1, 0);
    tv[3] = mkv(0, 0, 32'h0,  1, 1, 32'hA5, 0, 1);
    tv[4] = mkv(0, 0, 32'h0,  1, 0, 32'hA5, 0, 1);
    tv[5] = mkv(0, 1, 32'h3C, 1, 0, 32'hA5, 1, 0);
    tv[6] = mkv(0, 1, 32'h4D, 1, 1, 32'h3C, 1, 0);
    tv[7] = mkv(0, 0, 32'h0,  1, 1, 32'h4D, 0, 1);
    tv[8] = mkv(0, 0, 32'h0,  1, 0, 32'h4D, 0, 1);
    for (int i = 0; i < 9; i++) begin
      reset = tv[i].rst; vld = '0; vld[0] = tv[i].v; din = tv[i].d;
      #1;
      chk("vec_ready", rdy[0], tv[i].rdy);
      @(posedge clk); #1;
      chk("vec_valid_o", vo[0], tv[i].vo);
      chk("vec_out", dout[0], tv[i].out);
      chk("vec_count", cnt[0], tv[i].cnt);
      chk("vec_idle", idle_w[0], tv[i].idle);
    end

    // II=1: eight back-to-back words give eight contiguous pulses.
    do_reset(0); cur_ii = 1; clear_stats();
    for (int k = 1; k <= 8; k++) push_hold(0, k);
    drain(0, 5);
    chk("ii1_pulses", pulses, 8);
    chk("ii1_contiguous", last_seen - first_pulse, 7);
    check_order("ii1");

    // II=3: four words, occupancy peaks at 3 and ready never drops.
    do_reset(2); cur_ii = 3; clear_stats();
    for (int k = 1; k <= 4; k++) push_hold(2, k);
    drain(2, 15);
    chk("ii3_pulses", pulses, 4);
    chk("ii3_max_count", max_cnt, 3);
    chk("ii3_ready_dropped", saw_rdy0, 0);
    check_order("ii3");

    // II=4: six words fill the buffer; full blocks accept even on an issue cycle.
    do_reset(3); cur_ii = 4; clear_stats();
    for (int k = 1; k <= 6; k++) push_hold(3, k);
    drain(3, 30);
    chk("ii4_pulses", pulses, 6);
    chk("ii4_max_count", max_cnt, 4);
    chk("ii4_full_issue", saw_full_issue, 1);
    check_order("ii4");
`ifdef RV_PULSE_ISSUE_STALL_CNT_EN
    chk("ii4_stall_cnt", stall[3], m_stall);
`endif

    // Mid-stream reset with three words buffered and a pulse in flight.
    do_reset(1); cur_ii = 2; clear_stats();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 1'b1, 32'h100 + i, acc);
      if (vo[1] && cnt[1] == 3) found = 1;
    end
    chk("midrst_reached", found, 1);
    do_reset(1); cur_ii = 2; clear_stats();
    push_hold(1, 32'h7);
    drain(1, 6);
    chk("midrst_pulses", pulses, 1);
    chk("midrst_word", (issued.size() > 0) ? issued[0] : 32'hDEAD, 32'h7);

    // Random traffic against the model for II in {1,2,5}.
    for (int r = 0; r < 3; r++) begin
      ii = (r == 0) ? 1 : (r == 1) ? 2 : 5;
      s  = ii - 1;
      do_reset(s); cur_ii = ii; clear_stats();
      nsent = 0; pending = 0; word = '0;
      for (int t = 0; t < 20000 && !(nsent == 1000 && pulses == 1000); t++) begin
        if (!pending && nsent < 1000 && $urandom_range(0, 1) == 1) begin
          pending = 1;
          word    = $urandom;
        end
        if (pending) begin
          cycle(s, 1'b1, word, acc);
          if (acc) begin
            pending = 0;
            nsent++;
          end
        end else begin
          cycle(s, 1'b0, '0, acc);
        end
      end
      chk("rand_sent", nsent, 1000);
      chk("rand_pulses", pulses, 1000);
      check_order("rand");
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
